// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, sequencer state encoding and a
// helper used by the ALU, the decoder and the ALU sharing controller.
package alu_pkg;

  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_SUB     = 4'b0001;
  localparam logic [3:0] ALU_AND     = 4'b0010;
  localparam logic [3:0] ALU_XOR     = 4'b0011;
  localparam logic [3:0] ALU_OR      = 4'b0100;
  localparam logic [3:0] ALU_FUN_MAX = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } alu_ctrl_state_e;

  // Codes above ALU_FUN_MAX leave the ALU output undefined.
  function automatic logic fun_ok(input logic [3:0] fun);
    return fun <= ALU_FUN_MAX;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found searching upward from last_i+1 (wrapping mod NREQ).
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o,
  output logic            any_o
);

  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    sum       = '0;
    idx       = '0;
    // One extra bit holds last+i (at most 2*NREQ-1) before the wrap.
    for (int i = 1; i <= NREQ; i++) begin
      sum = {1'b0, last_i} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      idx = sum[IDW-1:0];
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU among NREQ requesters: round-robin accept,
// registered operands for one EXEC cycle, held response with requester ID.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = 32,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ-1:0]      req_sel_i,
  input  logic [4*NREQ-1:0]    req_fun_i,
  input  logic [XLEN*NREQ-1:0] req_a_i,
  input  logic [XLEN*NREQ-1:0] req_b_i,
  input  logic [XLEN*NREQ-1:0] req_imm_i,
  output logic                 alu_sel_o,
  output logic [3:0]           alu_fun_o,
  output logic [XLEN-1:0]      alu_a_o,
  output logic [XLEN-1:0]      alu_b_o,
  output logic [XLEN-1:0]      alu_imm_o,
  input  logic [XLEN-1:0]      alu_out_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [IDW-1:0]       rsp_id_o,
  output logic [XLEN-1:0]      rsp_data_o,
  output logic                 rsp_err_o
);

  alu_ctrl_state_e state_q, state_d;
  logic [IDW-1:0]  last_q, last_d, id_q, id_d;
  logic            sel_q, sel_d, err_q, err_d;
  logic [3:0]      fun_q, fun_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d, data_q, data_d;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            any, accept, capture;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i     (req_valid_i),
    .last_i    (last_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (any)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: if (any) begin
        accept  = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        capture = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Gated by reset so ready cannot leak out while valids are held in reset.
  assign req_ready_o = (state_q == ST_IDLE && rst_ni) ? gnt : '0;

  always_comb begin
    sel_d  = sel_q;
    fun_d  = fun_q;
    a_d    = a_q;
    b_d    = b_q;
    imm_d  = imm_q;
    data_d = data_q;
    err_d  = err_q;
    id_d   = accept ? gnt_idx : id_q;
    last_d = accept ? gnt_idx : last_q;
    if (accept) begin
      for (int k = 0; k < NREQ; k++) begin
        if (gnt[k]) begin
          sel_d = req_sel_i[k];
          fun_d = req_fun_i[4*k +: 4];
          a_d   = req_a_i[XLEN*k +: XLEN];
          b_d   = req_b_i[XLEN*k +: XLEN];
          imm_d = req_imm_i[XLEN*k +: XLEN];
        end
      end
    end
    if (capture) begin
      data_d = fun_ok(fun_q) ? alu_out_i : '0;
      err_d  = !fun_ok(fun_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      last_q  <= IDW'(NREQ-1);
      id_q    <= '0;
      sel_q   <= 1'b0;
      fun_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      sel_q   <= sel_d;
      fun_q   <= fun_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign alu_sel_o   = sel_q;
  assign alu_fun_o   = fun_q;
  assign alu_a_o     = a_q;
  assign alu_b_o     = b_q;
  assign alu_imm_o   = imm_q;
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_id_o    = id_q;
  assign rsp_data_o  = data_q;
  assign rsp_err_o   = err_q;

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and round-robin arbiter sharing the single combinational `alu` between NREQ requesters (e.g. decode, address-gen, branch-compare) in the core. Accepts one request at a time over valid/ready, registers operands onto the ALU's ports, captures the result one cycle later and returns it with the requester ID over a valid/ready response channel. Flags unsupported function codes instead of returning the ALU's undefined output.

## Interface
- `NREQ`, 2: number of requesters, 2..8
- `XLEN`, 32: operand/result width
- `IDW`, `$clog2(NREQ)`: requester ID width (derived)

- `clk_i`  in  1  clock, rising edge
- `rst_ni`  in  1  reset, asynchronous, active-low
- `req_valid_i`  in  NREQ  per-requester request valid
- `req_ready_o`  out  NREQ  per-requester accept; at most one bit high
- `req_sel_i`  in  NREQ  per-requester B-source select: 1 = imm, 0 = rs2
- `req_fun_i`  in  4*NREQ  per-requester function code, requester k in bits [4k+3:4k]
- `req_a_i`, `req_b_i`, `req_imm_i`  in  XLEN*NREQ  per-requester rs1 / rs2 / extended imm, same packing
- `alu_sel_o`, `alu_fun_o`  out  1, 4  to ALU select and function inputs
- `alu_a_o`, `alu_b_o`, `alu_imm_o`  out  XLEN  to ALU operand inputs
- `alu_out_i`  in  XLEN  ALU result
- `rsp_valid_o`  out  1  response valid
- `rsp_ready_i`  in  1  response consumer ready
- `rsp_id_o`  out  IDW  index of the requester owning the response
- `rsp_data_o`  out  XLEN  result
- `rsp_err_o`  out  1  function code unsupported (>4'b0100)

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Round-robin search over `req_valid_i`, starting at `(last_grant+1) mod NREQ`.
  - Winner's `req_ready_o` is high combinationally in the same cycle. All other ready bits are 0.
  - On handshake: latch winner's sel/fun/a/b/imm into operand registers, latch ID, set `last_grant` = winner, go to EXEC.
  - No valid requests: stay in IDLE, all ready bits 0.
- EXEC: ALU sees the registered operands.
  - At the cycle end, capture `rsp_data_o` = `alu_out_i`, `rsp_err_o` = 0 for fun 0000..0100.
  - For any other fun code: `rsp_data_o` = 0 and `rsp_err_o` = 1.
  - Go to RESP.
- RESP: `rsp_valid_o` = 1; data/ID/err are held stable. On `rsp_ready_i` = 1, go to IDLE. `req_ready_o` is 0 in EXEC and RESP.
- Requesters must hold valid and payload stable until ready. Valid must not depend on ready. Deasserting valid before grant is legal: the request is not taken.
- `alu_*_o` are driven only from operand registers and hold their value outside EXEC.

## Timing
- Reset (async, `rst_ni` = 0):
  - state = IDLE, `last_grant` = NREQ-1 (requester 0 has first priority).
  - All outputs 0: `req_ready_o`, `alu_*_o`, `rsp_valid_o`, `rsp_id_o`, `rsp_data_o`, `rsp_err_o`.
- Reset mid-operation: the in-flight request and response are discarded with no response issued. Reset release is synchronized by the reset-sync elsewhere.
- Latency:
  - Handshake at edge N.
  - ALU inputs are valid after edge N.
  - `rsp_valid_o` rises after edge N+1.
  - The earliest response handshake is at edge N+2.
  - The earliest next request handshake is at edge N+3.
- Throughput: one operation per 3 cycles when `rsp_ready_i` is held at 1. A stalled `rsp_ready_i` extends RESP indefinitely.
- Fairness: a continuously valid requester is granted within NREQ grants.
- Arithmetic is in the ALU. Results wrap mod 2^XLEN and no overflow is flagged.

## Structure
- Shared package `alu_pkg`:
  - Function-code constants `ALU_ADD`=4'b0000, `ALU_SUB`=0001, `ALU_AND`=0010, `ALU_XOR`=0011, `ALU_OR`=0100, `ALU_FUN_MAX`=0100.
  - State enum `alu_ctrl_state_e`.
  - Shared with the ALU and decoder.
- Sub-module `rr_arbiter`: parameterized NREQ, combinational one-hot grant from request vector and `last_grant` pointer. Reused by other shared resources.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- Reset, then requester 0 issues ADD a=5 b=7 sel=0 -> ready[0] same cycle; `alu_fun_o`=0000 one cycle later; `rsp_valid_o` next cycle with data=12, id=0, err=0.
- Requesters 0 and 1 both valid continuously with SUB 10-3 and OR imm=0xF0 \| a=0x0F, sel=1 -> grants alternate 0,1,0,1; responses 7 (id 0) and 0xFF (id 1); one op every 3 cycles.
- Requester 1 issues fun=4'b1010; `rsp_ready_i` held 0 for 5 cycles -> `rsp_valid_o` held 5+ cycles, data=0, err=1, id=1; no new `req_ready_o` until response accepted.
- ADD 0xFFFFFFFF+1 -> data=0, err=0 (wrap). XOR 0xAAAA5555^0xFFFF0000 -> 0x55555555.
- Assert `rst_ni`=0 during EXEC -> all outputs 0 immediately; after release, no stale response; requester 0 wins a simultaneous request from 0 and 1.
- NREQ=4, all valid -> grant order 0,1,2,3,0; requester 2 dropping valid before grant is skipped without deadlock.
